// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector: KMP transition and border
// functions, evaluated only at elaboration to build constant next-state tables.
package seq_det_pkg;

  localparam int SEQ_DET_MAX_LEN = 16;

  // Wide enough for any matched-prefix length of a pattern up to 16 bits.
  typedef logic [3:0] seq_det_idx_t;

  // Longest proper prefix of the pattern that is a suffix of
  // (first k pattern bits, then b). Bit 0 of the sequence is pattern[len-1].
  // The result is capped below len; the full-match case is handled separately.
  function automatic seq_det_idx_t seq_det_next(input logic [15:0] pattern,
                                                input int len,
                                                input seq_det_idx_t k,
                                                input logic b);
    int   best;
    int   kk;
    int   idx;
    logic ok;
    logic sb;
    best = 0;
    kk   = int'(k);
    for (int j = 1; j < SEQ_DET_MAX_LEN; j++) begin
      if (j <= kk + 1 && j < len) begin
        ok = 1'b1;
        for (int t = 0; t < SEQ_DET_MAX_LEN; t++) begin
          if (t < j) begin
            idx = kk + 1 - j + t;
            sb  = (idx == kk) ? b : pattern[len-1-idx];
            if (sb != pattern[len-1-t]) ok = 1'b0;
          end
        end
        if (ok) best = j;
      end
    end
    return seq_det_idx_t'(best);
  endfunction

  // Longest proper border of the whole pattern: where an overlapping search
  // resumes after a full match.
  function automatic seq_det_idx_t seq_det_border(input logic [15:0] pattern,
                                                  input int len);
    return seq_det_next(pattern, len, seq_det_idx_t'(len - 1), pattern[0]);
  endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Saturating event counter, zeroed by async reset or synchronous clr.
// Counts one per cycle with inc high and sticks at all-ones.
module seq_det_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_detector_mealy_param.sv
// Mealy detector for a LEN-bit serial pattern (KMP automaton); match is same-cycle,
// match_q one cycle later. SEQ_DET_MATCH_COUNT_EN adds a saturating match counter.
module seq_detector_mealy_param
  import seq_det_pkg::*;
#(
  parameter int             LEN     = 4,
  parameter logic [LEN-1:0] PATTERN = 4'b1101,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             din_valid,
  input  logic             din,
  input  logic             overlap_en,
  output logic             match,
  output logic             match_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int            SW     = (LEN > 2) ? $clog2(LEN) : 1;
  localparam logic [SW-1:0] LAST_K = SW'(LEN - 1);
  localparam seq_det_idx_t  BORDER = seq_det_border(16'(PATTERN), LEN);
  localparam logic [SW-1:0] BORDER_K = BORDER[SW-1:0];

  logic [SW-1:0] k;
  logic [SW-1:0] k_nomatch;
  logic [SW-1:0] k_nxt;
  logic          k_legal;
  logic [SW-1:0] delta0 [LEN];
  logic [SW-1:0] delta1 [LEN];

  // Constant transition table, one entry per (k, bit); ties off to wiring.
  for (genvar i = 0; i < LEN; i++) begin : g_delta
    localparam seq_det_idx_t D0 = seq_det_next(16'(PATTERN), LEN, seq_det_idx_t'(i), 1'b0);
    localparam seq_det_idx_t D1 = seq_det_next(16'(PATTERN), LEN, seq_det_idx_t'(i), 1'b1);
    assign delta0[i] = D0[SW-1:0];
    assign delta1[i] = D1[SW-1:0];
  end

  always_comb begin
    k_nomatch = '0;
    k_legal   = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      if (k == SW'(i)) begin
        k_nomatch = din ? delta1[i] : delta0[i];
        k_legal   = 1'b1;
      end
    end
  end

  assign match = din_valid && (k == LAST_K) && (din == PATTERN[0]);

  // Illegal encodings recover to idle regardless of din_valid.
  always_comb begin
    k_nxt = k;
    if (!k_legal) begin
      k_nxt = '0;
    end else if (din_valid) begin
      if (match) k_nxt = overlap_en ? BORDER_K : '0;
      else       k_nxt = k_nomatch;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k       <= '0;
      match_q <= 1'b0;
    end else if (clear) begin
      k       <= '0;
      match_q <= 1'b0;
    end else begin
      k       <= k_nxt;
      match_q <= match;
    end
  end

`ifdef SEQ_DET_MATCH_COUNT_EN
  seq_det_sat_counter #(
    .CNT_W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear),
    .inc   (match),
    .cnt   (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detector_mealy_param.sv
// Directed bench: default 1101 detector plus a LEN=3 / 010 / CNT_W=2 instance.
module tb_seq_detector_mealy_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic       a_valid, a_din, a_ovl, a_match, a_match_q;
  logic [7:0] a_cnt;
  logic       b_valid, b_din, b_ovl, b_match, b_match_q;
  logic [1:0] b_cnt;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  seq_detector_mealy_param dut_a (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .din_valid  (a_valid),
    .din        (a_din),
    .overlap_en (a_ovl),
    .match      (a_match),
    .match_q    (a_match_q),
    .match_cnt  (a_cnt)
  );

  seq_detector_mealy_param #(
    .LEN     (3),
    .PATTERN (3'b010),
    .CNT_W   (2)
  ) dut_b (
    .clk        (clk),
    .reset      (reset),
    .clear      (clear),
    .din_valid  (b_valid),
    .din        (b_din),
    .overlap_en (b_ovl),
    .match      (b_match),
    .match_q    (b_match_q),
    .match_cnt  (b_cnt)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one bit into dut_a at negedge, check match before the edge and match_q after.
  task automatic stepa(input string tag, input logic v, input logic d, input logic em);
    @(negedge clk);
    a_valid = v;
    a_din   = d;
    #1;
    chk({tag, " match"}, 8'(a_match), 8'(em));
    @(posedge clk);
    #1;
    chk({tag, " match_q"}, 8'(a_match_q), 8'(em));
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    clear   = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  logic [8:0] b_bits;
  logic [1:0] b_exp_cnt [9];

  initial begin
    reset   = 1'b1;
    clear   = 1'b0;
    a_valid = 1'b0; a_din = 1'b0; a_ovl = 1'b0;
    b_valid = 1'b0; b_din = 1'b0; b_ovl = 1'b1;
    #2;
    chk("reset match_q", 8'(a_match_q), 8'd0);
    chk("reset match", 8'(a_match), 8'd0);
    chk("reset cnt", a_cnt, 8'd0);
    chk("reset b cnt", 8'(b_cnt), 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // Non-overlap: 1101101 -> only bit 4
    a_ovl = 1'b0;
    stepa("nov b1", 1, 1, 0); stepa("nov b2", 1, 1, 0); stepa("nov b3", 1, 0, 0);
    stepa("nov b4", 1, 1, 1); stepa("nov b5", 1, 1, 0); stepa("nov b6", 1, 0, 0);
    stepa("nov b7", 1, 1, 0);
    pulse_clear();

    // Overlap: same stream -> bits 4 and 7
    a_ovl = 1'b1;
    stepa("ov b1", 1, 1, 0); stepa("ov b2", 1, 1, 0); stepa("ov b3", 1, 0, 0);
    stepa("ov b4", 1, 1, 1); stepa("ov b5", 1, 1, 0); stepa("ov b6", 1, 0, 0);
    stepa("ov b7", 1, 1, 1);
    pulse_clear();

    // Fallback: 11101 -> bit 5
    a_ovl = 1'b0;
    stepa("fb b1", 1, 1, 0); stepa("fb b2", 1, 1, 0); stepa("fb b3", 1, 1, 0);
    stepa("fb b4", 1, 0, 0); stepa("fb b5", 1, 1, 1);
    pulse_clear();

    // Valid gaps
    stepa("gap b1", 1, 1, 0); stepa("gap b2", 1, 1, 0);
    stepa("gap g1", 0, 1, 0); stepa("gap g2", 0, 1, 0); stepa("gap g3", 0, 1, 0);
    stepa("gap b3", 1, 0, 0); stepa("gap b4", 1, 1, 1);
    // Gap while one bit short of a match must not fire
    stepa("gapk b1", 1, 1, 0); stepa("gapk b2", 1, 1, 0); stepa("gapk b3", 1, 0, 0);
    stepa("gapk g", 0, 1, 0); stepa("gapk b4", 1, 1, 1);
    pulse_clear();

    // Clear coincident with a match: match still high, state and match_q zeroed
    a_ovl = 1'b1;
    stepa("clm b1", 1, 1, 0); stepa("clm b2", 1, 1, 0); stepa("clm b3", 1, 0, 0);
    @(negedge clk);
    a_valid = 1'b1; a_din = 1'b1; clear = 1'b1;
    #1;
    chk("clm b4 match", 8'(a_match), 8'd1);
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clm b4 match_q", 8'(a_match_q), 8'd0);
    stepa("clm b5", 1, 1, 0); stepa("clm b6", 1, 0, 0); stepa("clm b7", 1, 1, 0);
    pulse_clear();

    // Async reset while match_q is high
    stepa("rq b1", 1, 1, 0); stepa("rq b2", 1, 1, 0); stepa("rq b3", 1, 0, 0);
    stepa("rq b4", 1, 1, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rq async match_q", 8'(a_match_q), 8'd0);
    @(negedge clk);
    reset = 1'b0;

    // Reset pulse between edges erases partial sequence 110
    stepa("rst b1", 1, 1, 0); stepa("rst b2", 1, 1, 0); stepa("rst b3", 1, 0, 0);
    @(negedge clk);
    a_valid = 1'b0;
    #1 reset = 1'b1;
    #1 reset = 1'b0;
    stepa("rst b4", 1, 1, 0);
    pulse_clear();

    // LEN=3 pattern 010, overlapping, counter saturating at 3
    b_bits = 9'b010101010;
`ifdef SEQ_DET_MATCH_COUNT_EN
    b_exp_cnt = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3};
`else
    b_exp_cnt = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      b_valid = 1'b1;
      b_din   = b_bits[8-i];
      #1;
      chk($sformatf("b bit%0d match", i + 1), 8'(b_match), 8'((i >= 2) && (i % 2 == 0)));
      @(posedge clk);
      #1;
      chk($sformatf("b bit%0d cnt", i + 1), 8'(b_cnt), 8'(b_exp_cnt[i]));
    end
    pulse_clear();
    chk("b cnt after clear", 8'(b_cnt), 8'd0);
    chk("b match_q after clear", 8'(b_match_q), 8'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
